imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/imem_array.sv | 82 ++++++++
 rtl/imem_responder.sv | 143 ++++++++++++++
 tb/tb_imem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared encodings for the instruction-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_WAIT_ENC = 2'd1;
    localparam logic [1:0] ST_RESP_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_WAIT = ST_WAIT_ENC,
        ST_RESP = ST_RESP_ENC
    } imem_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    function automatic logic word_in_range(input logic [31:0] byte_addr,
                                           input int unsigned depth);
        return {2'b00, byte_addr[31:2]} < depth;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_array.sv
// ============================================================================
// Module      : imem_array
// Description : Word storage with a preload write port and a registered,
//               write-first read port that flags bad addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_array
    import riscv_pkg::*;
#(
    parameter int          DEPTH    = 1024,
    parameter logic [31:0] NOP_INST = RV_NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic        rd_clr,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_err_q, rd_err_d;
    logic        wr_ok;
    logic        rd_bad;
    logic        unused_wr_lsb;

    assign wr_ok         = wr_en && word_in_range(wr_addr, DEPTH);
    assign rd_bad        = (rd_addr[1:0] != 2'b00) || !word_in_range(rd_addr, DEPTH);
    assign unused_wr_lsb = ^wr_addr[1:0];

    // Storage is deliberately outside reset so preloaded code survives it.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_addr[AW+1:2]] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        rd_err_d  = rd_err_q;
        if (rd_clr) begin
            rd_data_d = NOP_INST;
            rd_err_d  = 1'b0;
        end else if (rd_en) begin
            if (rd_bad) begin
                rd_data_d = NOP_INST;
                rd_err_d  = 1'b1;
            end else if (wr_en && (wr_addr[31:2] == rd_addr[31:2])) begin
                rd_data_d = wr_data;
                rd_err_d  = 1'b0;
            end else begin
                rd_data_d = mem_q[rd_addr[AW+1:2]];
                rd_err_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q <= NOP_INST;
            rd_err_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_err  = rd_err_q;

endmodule

`default_nettype wire

// File: rtl/imem_responder.sv
// ============================================================================
// Module      : imem_responder
// Description : Instruction-fetch responder: one-cycle fetch with stall/flush,
//               optional wait states under macro IMEM_WAIT_STATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_responder
    import riscv_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] NOP_INST    = RV_NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] inst_addr,
    input  logic        stall,
    input  logic        flush,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        busy,
    output logic        fetch_err
);

    imem_state_e state_q, state_d;
    logic        accept;
    logic        rd_en;
    logic [31:0] rd_addr;

    // A held (stalled) response blocks new requests; flush blocks everything.
    assign accept = req_valid && !flush &&
                    ((state_q == ST_IDLE) || ((state_q == ST_RESP) && !stall));

`ifdef IMEM_WAIT_STATE_EN
    localparam bit USE_WAIT = (WAIT_CYCLES > 0);
    localparam int CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            addr_d = inst_addr;
            if (USE_WAIT) begin
                state_d = ST_WAIT;
                cnt_d   = CW'(WAIT_CYCLES - 1);
            end else begin
                state_d = ST_RESP;
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (!stall) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            addr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
        end
    end

    // The array is read on the last wait cycle so its output lands with RESP.
    assign rd_en   = USE_WAIT ? ((state_q == ST_WAIT) && (cnt_q == '0) && !flush) : accept;
    assign rd_addr = USE_WAIT ? addr_q : inst_addr;
    assign busy    = (state_q == ST_WAIT);
`else
    logic unused_wait_cfg;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            state_d = ST_RESP;
        end else if ((state_q == ST_RESP) && !stall) begin
            state_d = ST_IDLE;
        end
    end

    assign rd_en           = accept;
    assign rd_addr         = inst_addr;
    assign busy            = 1'b0;
    assign unused_wait_cfg = (WAIT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign inst_valid = (state_q == ST_RESP);

    imem_array #(
        .DEPTH    (DEPTH),
        .NOP_INST (NOP_INST)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (load_we),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (rd_en),
        .rd_clr  (flush),
        .rd_addr (rd_addr),
        .rd_data (inst),
        .rd_err  (fetch_err)
    );

endmodule

`default_nettype wire

// File: tb/tb_imem_responder.sv
// ============================================================================
// Module      : tb_imem_responder
// Description : Directed scoreboard bench for imem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_responder;

    localparam int          DEPTH       = 1024;
    localparam int          WAIT_CYCLES = 2;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } resp_t;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        stall     = 1'b0;
    logic        flush     = 1'b0;
    logic        load_we   = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        busy;
    logic        fetch_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    resp_t       sb_q[$];
    logic [31:0] bmem [DEPTH];
    logic        m_valid = 1'b0;
    resp_t       m_resp  = {NOP, 1'b0};

    always #5 clk = ~clk;

    imem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES),
        .NOP_INST    (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .inst_addr  (inst_addr),
        .stall      (stall),
        .flush      (flush),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .inst       (inst),
        .inst_valid (inst_valid),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic resp_t expect_fetch(input logic [31:0] a);
        if (a[1:0] != 2'b00 || {2'b00, a[31:2]} >= 32'(DEPTH))
            return {NOP, 1'b1};
        if (load_we && load_addr[31:2] == a[31:2])
            return {load_data, 1'b0};
        return {bmem[a[11:2]], 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with the reference model advanced from the current inputs.
    task automatic cycle(input string tag);
        bit fresh = 1'b0;
        if (!reset) begin
            m_valid = 1'b0;
            m_resp  = {NOP, 1'b0};
            sb_q.delete();
        end else if (flush) begin
            m_valid = 1'b0;
            m_resp  = {NOP, 1'b0};
        end else if (req_valid && (!m_valid || !stall)) begin
            sb_q.push_back(expect_fetch(inst_addr));
            m_valid = 1'b1;
            fresh   = 1'b1;
        end else if (m_valid && !stall) begin
            m_valid = 1'b0;
        end
        if (load_we && {2'b00, load_addr[31:2]} < 32'(DEPTH))
            bmem[load_addr[11:2]] = load_data;
        tick();
        if (fresh) m_resp = sb_q.pop_front();
        check({tag, "_valid"}, {31'd0, inst_valid}, {31'd0, m_valid});
        check({tag, "_inst"},  inst, m_resp.inst);
        check({tag, "_err"},   {31'd0, fetch_err}, {31'd0, m_resp.err});
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] a, input string tag);
        req_valid = 1'b1;
        inst_addr = a;
        cycle(tag);
    endtask

    task automatic wait_fetch(input logic [31:0] a, input string tag);
        resp_t e;
        sb_q.push_back(expect_fetch(a));
        req_valid = 1'b1;
        inst_addr = a;
        for (int k = 0; k < WAIT_CYCLES; k++) begin
            tick();
            req_valid = 1'b0;
            check({tag, "_busy"},  {31'd0, busy}, 32'd1);
            check({tag, "_wval"},  {31'd0, inst_valid}, 32'd0);
        end
        tick();
        e = sb_q.pop_front();
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_valid"},    {31'd0, inst_valid}, 32'd1);
        check({tag, "_inst"},     inst, e.inst);
        check({tag, "_err"},      {31'd0, fetch_err}, {31'd0, e.err});
        tick();
        check({tag, "_idle"},     {31'd0, inst_valid}, 32'd0);
    endtask

    initial begin
        cycle("rst0");
        cycle("rst1");
        reset = 1'b1;

        // Preload program words plus the last in-range word; the 4*DEPTH write must be dropped.
        load_we = 1'b1;
        load_addr = 32'h0;  load_data = 32'h0050_0093; cycle("ld0");
        load_addr = 32'h4;  load_data = 32'h00A0_0113; cycle("ld1");
        load_addr = 32'h8;  load_data = 32'h0020_81B3; cycle("ld2");
        load_addr = 32'hC;  load_data = 32'h0000_0013; cycle("ld3");
        load_addr = 32'(4 * (DEPTH - 1)); load_data = 32'hDEAD_BEEF; cycle("ld_top");
        load_addr = 32'(4 * DEPTH);       load_data = 32'hBAD0_BAD0; cycle("ld_oor");
        load_we = 1'b0;

`ifdef IMEM_WAIT_STATE_EN
        wait_fetch(32'h0, "wait0");

        sb_q.push_back(expect_fetch(32'h4));
        req_valid = 1'b1; inst_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        check("rstw_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        void'(sb_q.pop_front());
        check("rstw_valid", {31'd0, inst_valid}, 32'd0);
        check("rstw_busy",  {31'd0, busy}, 32'd0);
        check("rstw_inst",  inst, NOP);
        reset = 1'b1;
        tick();
        check("rstw_after", {31'd0, inst_valid}, 32'd0);

        wait_fetch(32'h4, "keep4");
        wait_fetch(32'h6, "wmis");
`else
        fetch(32'h0, "b2b0");
        fetch(32'h4, "b2b1");
        fetch(32'h8, "b2b2");
        fetch(32'hC, "b2b3");
        req_valid = 1'b0; cycle("b2b_idle");

        fetch(32'h4, "st_req");
        stall = 1'b1;
        fetch(32'h8, "st_h0");
        fetch(32'h8, "st_h1");
        fetch(32'h8, "st_h2");
        stall = 1'b0;
        fetch(32'h8, "st_rel");
        req_valid = 1'b0; cycle("st_idle");

        fetch(32'h6, "mis");
        fetch(32'(4 * DEPTH), "oor");
        fetch(32'(4 * (DEPTH - 1)), "top");
        fetch(32'h0, "alias0");
        req_valid = 1'b0; cycle("err_idle");

        fetch(32'h8, "fl_req");
        flush = 1'b1; stall = 1'b1;
        fetch(32'hC, "fl_hit");
        flush = 1'b0; stall = 1'b0;
        req_valid = 1'b0; cycle("fl_idle");
        flush = 1'b1;
        fetch(32'h4, "fl_idle_req");
        flush = 1'b0;
        req_valid = 1'b0; cycle("fl_done");

        load_we = 1'b1; load_addr = 32'h10; load_data = 32'h1234_5678;
        fetch(32'h10, "wf");
        load_we = 1'b0;
        req_valid = 1'b0; cycle("wf_idle");

        fetch(32'h0, "rst_req");
        reset = 1'b0;
        fetch(32'h4, "rst_mid");
        reset = 1'b1;
        req_valid = 1'b0; cycle("rst_rel");
        fetch(32'h0, "keep0");
        fetch(32'h4, "keep1");
        fetch(32'h8, "keep2");
        fetch(32'h10, "keep4");
        req_valid = 1'b0; cycle("keep_idle");
`endif

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
